// File: rtl/amm_arb_pkg.sv
`default_nettype none
// amm_arb_pkg -- shared types, constants and width helper for amm_rr_arbiter.
// Revision 1.0
package amm_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  // Never returns less than 1 so single-entry ranges still get a real bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// rr_pick -- combinational round-robin pick: first requester above 'last', wrapping.
// Revision 1.0
module rr_pick
  import amm_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int GW    = clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    winner,
  output logic             any
);

  always_comb begin
    int          idx;
    logic [GW-1:0] cand;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx  = (int'(last) + k) % NUM_M;
      cand = GW'(idx);
      if (!any && req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/amm_rr_arbiter.sv
`default_nettype none
// amm_rr_arbiter -- round-robin sharing of one Avalon-MM register slave among NUM_M masters.
// Revision 1.0
module amm_rr_arbiter
  import amm_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADDRW   = 8,
  parameter int DATAW   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M*ADDRW-1:0]   m_addr,
  input  logic [NUM_M-1:0]         m_read,
  input  logic [NUM_M-1:0]         m_write,
  input  logic [NUM_M*DATAW-1:0]   m_writedata,
  input  logic [NUM_M*DATAW/8-1:0] m_byteenable,
  output logic [DATAW-1:0]         m_readdata,
  output logic [NUM_M-1:0]         m_waitrequest,
  output logic [ADDRW-1:0]         s_addr,
  output logic                     s_read,
  output logic                     s_write,
  output logic [DATAW-1:0]         s_writedata,
  output logic [DATAW/8-1:0]       s_byteenable,
  input  logic [DATAW-1:0]         s_readdata,
  input  logic                     s_waitrequest,
  output logic                     err
);

  localparam int GW = clog2(NUM_M);
  localparam int CW = clog2(TIMEOUT);
  localparam int BW = DATAW / 8;
  localparam logic [DATAW-1:0] ABORT_WORD = DATAW'(ABORT_DATA);

  arb_state_t       state, next_state;
  logic [GW-1:0]    gnt, last, winner;
  logic [CW-1:0]    wait_cnt;
  logic [NUM_M-1:0] req;
  logic             any, complete, abort, stall;

  assign req = m_read | m_write;

  rr_pick #(
    .NUM_M (NUM_M),
    .GW    (GW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last     <= GW'(NUM_M - 1);
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      err   <= abort;
      if (state == IDLE && any) begin
        gnt      <= winner;
        wait_cnt <= '0;
      end else if (stall) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (complete || abort) last <= gnt;
    end
  end

  // A dropped request leaves 'last' alone so the same master keeps its turn.
  always_comb begin
    next_state = state;
    complete   = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: if (any) next_state = BUSY;
      BUSY: begin
        if (!req[gnt]) begin
          next_state = IDLE;
        end else if (!s_waitrequest) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_waitrequest = '1;
    m_readdata    = s_readdata;
    s_addr        = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    s_byteenable  = '0;
    if (state == BUSY) begin
      s_addr             = m_addr[int'(gnt)*ADDRW +: ADDRW];
      s_writedata        = m_writedata[int'(gnt)*DATAW +: DATAW];
      s_byteenable       = m_byteenable[int'(gnt)*BW +: BW];
      s_write            = m_write[gnt];
      s_read             = m_read[gnt] & ~m_write[gnt];
      m_waitrequest[gnt] = s_waitrequest;
      if (abort) begin
        m_waitrequest[gnt] = 1'b0;
        m_readdata         = ABORT_WORD;
        s_read             = 1'b0;
        s_write            = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amm_rr_arbiter.sv
`default_nettype none
// tb_amm_rr_arbiter -- vector table, corner-case sequences and random run against a reference model.
// Revision 1.0
module tb_amm_rr_arbiter;

  localparam int NUM_M   = 2;
  localparam int ADDRW   = 8;
  localparam int DATAW   = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] WD0 = 32'hA5A5_0001;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_M*ADDRW-1:0]   m_addr;
  logic [NUM_M-1:0]         m_read, m_write;
  logic [NUM_M*DATAW-1:0]   m_writedata;
  logic [NUM_M*DATAW/8-1:0] m_byteenable;
  logic [DATAW-1:0]         m_readdata;
  logic [NUM_M-1:0]         m_waitrequest;
  logic [ADDRW-1:0]         s_addr;
  logic                     s_read, s_write;
  logic [DATAW-1:0]         s_writedata;
  logic [DATAW/8-1:0]       s_byteenable;
  logic [DATAW-1:0]         s_readdata;
  logic                     s_waitrequest;
  logic                     err;

  logic                     auto_slave;
  logic [DATAW-1:0]         rnd_rdata;

  int checks   = 0;
  int failures = 0;

  amm_rr_arbiter #(
    .NUM_M (NUM_M), .ADDRW (ADDRW), .DATAW (DATAW), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_addr        (m_addr),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .s_addr        (s_addr),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Register slave stand-in: fixed data per address, or random data.
  always_comb begin
    if (auto_slave) begin
      case (s_addr)
        8'h04:   s_readdata = 32'h0000_0011;
        8'h08:   s_readdata = 32'h0000_0022;
        default: s_readdata = 32'h0;
      endcase
    end else begin
      s_readdata = rnd_rdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    m_read        = '0;
    m_write       = '0;
    s_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    check("rst m_waitrequest", 64'(m_waitrequest), 64'h3);
    check("rst s_read", 64'(s_read), 64'h0);
    check("rst s_write", 64'(s_write), 64'h0);
    check("rst err", 64'(err), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rb;
    logic [1:0] rd, wr;
    logic [7:0] a0, a1;
    logic       sw;
    logic       e_sr, e_sw;
    logic [7:0] e_addr;
    logic [1:0] e_mw;
    logic [31:0] e_rd, e_wd;
    logic       e_err;
  } vec_t;

  vec_t vt [13];

  task automatic run_table();
    vt[0]  = '{1'b1, 2'b00, 2'b01, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 2'b00, 2'b01, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 2'b10, 32'h0, WD0,   1'b0};
    vt[2]  = '{1'b0, 2'b00, 2'b00, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b1, 1'b0, 8'h04, 2'b10, 32'h11, WD0,  1'b0};
    vt[5]  = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[6]  = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b1, 1'b0, 8'h08, 2'b01, 32'h22, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b1, 1'b0, 8'h04, 2'b10, 32'h11, WD0,  1'b0};
    vt[9]  = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[10] = '{1'b0, 2'b11, 2'b00, 8'h04, 8'h08, 1'b0, 1'b1, 1'b0, 8'h08, 2'b01, 32'h22, 32'h0, 1'b0};
    vt[11] = '{1'b1, 2'b01, 2'b01, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 32'h0, 32'h0, 1'b0};
    vt[12] = '{1'b0, 2'b01, 2'b01, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 8'h30, 2'b10, 32'h0, WD0,   1'b0};
    for (int i = 0; i < 13; i++) begin
      if (vt[i].rb) do_reset();
      m_read        = vt[i].rd;
      m_write       = vt[i].wr;
      m_addr        = {vt[i].a1, vt[i].a0};
      s_waitrequest = vt[i].sw;
      #3;
      check($sformatf("vec%0d s_read", i), 64'(s_read), 64'(vt[i].e_sr));
      check($sformatf("vec%0d s_write", i), 64'(s_write), 64'(vt[i].e_sw));
      check($sformatf("vec%0d s_addr", i), 64'(s_addr), 64'(vt[i].e_addr));
      check($sformatf("vec%0d m_waitrequest", i), 64'(m_waitrequest), 64'(vt[i].e_mw));
      check($sformatf("vec%0d m_readdata", i), 64'(m_readdata), 64'(vt[i].e_rd));
      check($sformatf("vec%0d s_writedata", i), 64'(s_writedata), 64'(vt[i].e_wd));
      check($sformatf("vec%0d err", i), 64'(err), 64'(vt[i].e_err));
      tick();
    end
  endtask

  task automatic seq_stall3();
    do_reset();
    m_read        = 2'b10;
    m_addr        = {8'h08, 8'h04};
    s_waitrequest = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 4) s_waitrequest = 1'b0;
      if (c == 5) m_read = 2'b00;
      #3;
      if (c <= 3) check($sformatf("stall c%0d m_waitrequest", c), 64'(m_waitrequest), 64'h3);
      if (c >= 1 && c <= 3) check($sformatf("stall c%0d s_read", c), 64'(s_read), 64'h1);
      if (c == 4) begin
        check("stall done m_waitrequest", 64'(m_waitrequest), 64'h1);
        check("stall done m_readdata", 64'(m_readdata), 64'h22);
      end
      check($sformatf("stall c%0d err", c), 64'(err), 64'h0);
      tick();
    end
  endtask

  task automatic seq_timeout();
    do_reset();
    m_read        = 2'b11;
    m_addr        = {8'h08, 8'h04};
    s_waitrequest = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      #3;
      if (c >= 1 && c <= 15) check($sformatf("to c%0d m_waitrequest", c), 64'(m_waitrequest), 64'h3);
      if (c == 16) begin
        check("to abort m_waitrequest", 64'(m_waitrequest), 64'h2);
        check("to abort m_readdata", 64'(m_readdata), 64'hDEAD_BEEF);
        check("to abort s_read", 64'(s_read), 64'h0);
      end
      if (c == 18) begin
        check("to next grant s_read", 64'(s_read), 64'h1);
        check("to next grant s_addr", 64'(s_addr), 64'h08);
      end
      check($sformatf("to c%0d err", c), 64'(err), (c == 17) ? 64'h1 : 64'h0);
      tick();
    end
    m_read = 2'b00;
  endtask

  task automatic seq_reset_mid();
    do_reset();
    m_write       = 2'b10;
    m_addr        = {8'h08, 8'h04};
    s_waitrequest = 1'b1;
    tick();
    tick();
    #1;
    check("rmid before s_write", 64'(s_write), 64'h1);
    rst = 1'b1;
    #1;
    check("rmid s_write", 64'(s_write), 64'h0);
    check("rmid m_waitrequest", 64'(m_waitrequest), 64'h3);
    tick();
    rst           = 1'b0;
    m_write       = 2'b11;
    s_waitrequest = 1'b0;
    #3;
    check("rmid idle m_waitrequest", 64'(m_waitrequest), 64'h3);
    tick();
    #3;
    check("rmid first grant s_addr", 64'(s_addr), 64'h04);
    check("rmid first grant m_waitrequest", 64'(m_waitrequest), 64'h2);
    tick();
    m_write = 2'b00;
  endtask

  task automatic seq_drop();
    do_reset();
    m_read        = 2'b01;
    m_addr        = {8'h08, 8'h04};
    s_waitrequest = 1'b1;
    tick();
    #3;
    check("drop busy s_read", 64'(s_read), 64'h1);
    tick();
    m_read = 2'b00;
    #3;
    check("drop s_read", 64'(s_read), 64'h0);
    tick();
    m_read        = 2'b11;
    s_waitrequest = 1'b0;
    #3;
    check("drop idle err", 64'(err), 64'h0);
    check("drop idle m_waitrequest", 64'(m_waitrequest), 64'h3);
    tick();
    #3;
    check("drop after err", 64'(err), 64'h0);
    check("drop regrant s_addr", 64'(s_addr), 64'h04);
    check("drop regrant m_waitrequest", 64'(m_waitrequest), 64'h2);
    tick();
    m_read = 2'b00;
  endtask

  // Reference model: who owns the slave, who was last served, how long it has stalled.
  task automatic run_random(input int n);
    int owner, mlast, stalled;
    logic err_q, stuck, timed_out;
    logic [NUM_M-1:0] reqv, e_mw;
    logic e_sr, e_sw;
    logic [7:0] e_addr;
    logic [31:0] e_wd, e_rd;
    logic [3:0] e_be;
    do_reset();
    auto_slave = 1'b0;
    owner   = -1;
    mlast   = NUM_M - 1;
    stalled = 0;
    err_q   = 1'b0;
    stuck   = 1'b0;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < NUM_M; i++) begin
        if ($urandom_range(5) == 0) begin
          m_read[i]  = 1'($urandom_range(1));
          m_write[i] = 1'($urandom_range(1));
        end
      end
      m_addr       = NUM_M*ADDRW'($urandom);
      m_writedata  = {$urandom, $urandom};
      m_byteenable = 8'($urandom);
      rnd_rdata    = $urandom;
      if ($urandom_range(40) == 0) stuck = ~stuck;
      s_waitrequest = stuck | ($urandom_range(2) == 0);
      #3;
      reqv      = m_read | m_write;
      e_mw      = '1;
      e_sr      = 1'b0;
      e_sw      = 1'b0;
      e_addr    = '0;
      e_wd      = '0;
      e_be      = '0;
      e_rd      = s_readdata;
      timed_out = 1'b0;
      if (owner >= 0) begin
        e_addr = m_addr[owner*8 +: 8];
        e_wd   = m_writedata[owner*32 +: 32];
        e_be   = m_byteenable[owner*4 +: 4];
        e_sw   = m_write[owner];
        e_sr   = m_read[owner] && !m_write[owner];
        e_mw[owner] = s_waitrequest;
        if (reqv[owner] && s_waitrequest && stalled + 1 == TIMEOUT) begin
          timed_out   = 1'b1;
          e_mw[owner] = 1'b0;
          e_rd        = 32'hDEAD_BEEF;
          e_sr        = 1'b0;
          e_sw        = 1'b0;
        end
      end
      check("rnd s_read", 64'(s_read), 64'(e_sr));
      check("rnd s_write", 64'(s_write), 64'(e_sw));
      check("rnd s_addr", 64'(s_addr), 64'(e_addr));
      check("rnd s_writedata", 64'(s_writedata), 64'(e_wd));
      check("rnd s_byteenable", 64'(s_byteenable), 64'(e_be));
      check("rnd m_waitrequest", 64'(m_waitrequest), 64'(e_mw));
      check("rnd m_readdata", 64'(m_readdata), 64'(e_rd));
      check("rnd err", 64'(err), 64'(err_q));
      @(posedge clk);
      err_q = timed_out;
      if (owner < 0) begin
        for (int k = 1; k <= NUM_M; k++) begin
          if (owner < 0 && reqv[(mlast + k) % NUM_M]) owner = (mlast + k) % NUM_M;
        end
        stalled = 0;
      end else if (!reqv[owner]) begin
        owner = -1;
      end else if (!s_waitrequest || timed_out) begin
        mlast = owner;
        owner = -1;
      end else begin
        stalled++;
      end
      #1;
    end
    m_read  = '0;
    m_write = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    auto_slave    = 1'b1;
    rnd_rdata     = '0;
    m_read        = '0;
    m_write       = '0;
    m_addr        = '0;
    m_writedata   = {32'h0, WD0};
    m_byteenable  = 8'h0F;
    s_waitrequest = 1'b0;
    run_table();
    seq_stall3();
    seq_timeout();
    seq_reset_mid();
    seq_drop();
    run_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
